// File: rtl/banked_ram.sv
// Two-port, address-interleaved multi-bank RAM with byte enables, round-robin
// arbitration on bank conflicts and a one- or two-stage read pipeline.
module banked_ram #(
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned ADDR_WIDTH   = 20,
    parameter int unsigned NUM_BANKS    = 4,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    p0_req,
    input  logic                    p0_we,
    input  logic [DATA_WIDTH/8-1:0] p0_be,
    input  logic [ADDR_WIDTH-1:0]   p0_addr,
    input  logic [DATA_WIDTH-1:0]   p0_wdata,
    output logic                    p0_gnt,
    output logic                    p0_rvalid,
    output logic [DATA_WIDTH-1:0]   p0_rdata,
    input  logic                    p1_req,
    input  logic                    p1_we,
    input  logic [DATA_WIDTH/8-1:0] p1_be,
    input  logic [ADDR_WIDTH-1:0]   p1_addr,
    input  logic [DATA_WIDTH-1:0]   p1_wdata,
    output logic                    p1_gnt,
    output logic                    p1_rvalid,
    output logic [DATA_WIDTH-1:0]   p1_rdata
);

    localparam int unsigned BE_W      = DATA_WIDTH / 8;
    localparam int unsigned BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
    localparam int unsigned BSEL_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int unsigned ROW_W     = ADDR_WIDTH - BANK_BITS;
    localparam int unsigned DEPTH     = 1 << ROW_W;

    logic [1:0]            req;
    logic [1:0]            we;
    logic [1:0]            gnt;
    logic [1:0]            rvalid;
    logic [BE_W-1:0]       be        [2];
    logic [ADDR_WIDTH-1:0] addr      [2];
    logic [DATA_WIDTH-1:0] wdata     [2];
    logic [DATA_WIDTH-1:0] rdata     [2];
    logic [BSEL_W-1:0]     bank      [2];
    logic [ROW_W-1:0]      row       [2];
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
    logic                  conflict;
    logic                  prio;

    assign req   = {p1_req, p0_req};
    assign we    = {p1_we, p0_we};
    assign be    = '{p0_be, p1_be};
    assign addr  = '{p0_addr, p1_addr};
    assign wdata = '{p0_wdata, p1_wdata};

    assign p0_gnt    = gnt[0];
    assign p1_gnt    = gnt[1];
    assign p0_rvalid = rvalid[0];
    assign p1_rvalid = rvalid[1];
    assign p0_rdata  = rdata[0];
    assign p1_rdata  = rdata[1];

    // Address split: low bits pick the bank, the rest index the row.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            bank[p] = (BANK_BITS == 0) ? '0 : BSEL_W'(addr[p]);
            row[p]  = ROW_W'(addr[p] >> BANK_BITS);
        end
    end

    // Same-bank requests go to the priority holder; nothing is granted in reset.
    always_comb begin
        conflict = req[0] && req[1] && (bank[0] == bank[1]);
        gnt[0]   = rst_n && req[0] && (!conflict || !prio);
        gnt[1]   = rst_n && req[1] && (!conflict ||  prio);
    end

    // prio = 1 means port 1 wins the next conflict; it flips only on conflicts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (conflict) begin
            prio <= ~prio;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic                  hit0;
        logic                  hit1;
        logic                  a_we;
        logic [BE_W-1:0]       a_be;
        logic [ROW_W-1:0]      a_row;
        logic [DATA_WIDTH-1:0] a_wdata;

        // At most one granted port reaches a bank in any cycle.
        always_comb begin
            hit0    = gnt[0] && (bank[0] == BSEL_W'(b));
            hit1    = gnt[1] && (bank[1] == BSEL_W'(b));
            a_we    = hit1 ? we[1]    : we[0];
            a_be    = hit1 ? be[1]    : be[0];
            a_row   = hit1 ? row[1]   : row[0];
            a_wdata = hit1 ? wdata[1] : wdata[0];
        end

        assign bank_rdata[b] = mem[a_row];

        always_ff @(posedge clk) begin
            if ((hit0 || hit1) && a_we) begin
                for (int i = 0; i < int'(BE_W); i++) begin
                    if (a_be[i]) begin
                        mem[a_row][8*i +: 8] <= a_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic                  s1_valid;
        logic [DATA_WIDTH-1:0] s1_data;

        // Data is captured from the port's own bank at the grant edge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_valid <= 1'b0;
                s1_data  <= '0;
            end else begin
                s1_valid <= gnt[p] && !we[p];
                if (gnt[p] && !we[p]) begin
                    s1_data <= bank_rdata[bank[p]];
                end
            end
        end

        if (READ_LATENCY == 2) begin : g_lat2
            logic                  s2_valid;
            logic [DATA_WIDTH-1:0] s2_data;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign rvalid[p] = s2_valid;
            assign rdata[p]  = s2_data;
        end else begin : g_lat1
            assign rvalid[p] = s1_valid;
            assign rdata[p]  = s1_data;
        end
    end

endmodule

// File: tb/tb_banked_ram.sv
// Self-checking bench for banked_ram: a latency-1 and a latency-2 instance
// share all inputs, expected read data is queued at grant time.
module tb_banked_ram;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [7:0]  p0_be, p1_be;
    logic [9:0]  p0_addr, p1_addr;
    logic [63:0] p0_wdata, p1_wdata;

    logic        a_p0_gnt, a_p0_rvalid, a_p1_gnt, a_p1_rvalid;
    logic [63:0] a_p0_rdata, a_p1_rdata;
    logic        b_p0_gnt, b_p0_rvalid, b_p1_gnt, b_p1_rvalid;
    logic [63:0] b_p0_rdata, b_p1_rdata;

    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic [63:0] q2[$];
    int          checks = 0;
    int          failures = 0;
    logic        m_prio;

    always #5 clk = ~clk;

    banked_ram #(.DATA_WIDTH(64), .ADDR_WIDTH(10), .NUM_BANKS(4), .READ_LATENCY(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_be(p0_be), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(a_p0_gnt), .p0_rvalid(a_p0_rvalid), .p0_rdata(a_p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_be(p1_be), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(a_p1_gnt), .p1_rvalid(a_p1_rvalid), .p1_rdata(a_p1_rdata)
    );

    banked_ram #(.DATA_WIDTH(64), .ADDR_WIDTH(10), .NUM_BANKS(4), .READ_LATENCY(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_be(p0_be), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(b_p0_gnt), .p0_rvalid(b_p0_rvalid), .p0_rdata(b_p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_be(p1_be), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(b_p1_gnt), .p1_rvalid(b_p1_rvalid), .p1_rdata(b_p1_rdata)
    );

    function automatic logic [63:0] pat(input int i);
        return {32'hC0DE_0000 | 32'(i), 32'h1000_0000 + 32'(i * 3)};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        p0_req = 1'b0; p0_we = 1'b0; p0_be = 8'h00; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_be = 8'h00; p1_addr = '0; p1_wdata = '0;
    endtask

    task automatic p0_drive(input logic we, input logic [7:0] be, input logic [9:0] a, input logic [63:0] d);
        p0_req = 1'b1; p0_we = we; p0_be = be; p0_addr = a; p0_wdata = d;
    endtask

    task automatic p1_drive(input logic we, input logic [7:0] be, input logic [9:0] a, input logic [63:0] d);
        p1_req = 1'b1; p1_we = we; p1_be = be; p1_addr = a; p1_wdata = d;
    endtask

    task automatic test_reset();
        idle();
        p0_drive(1'b0, 8'h00, 10'h0, 64'h0);
        p1_drive(1'b0, 8'h00, 10'h1, 64'h0);
        #1;
        checks++; if ({a_p0_gnt, a_p1_gnt, b_p0_gnt, b_p1_gnt} !== 4'b0000) begin
            failures++; $display("FAIL reset_gnt: got %b want 0000", {a_p0_gnt, a_p1_gnt, b_p0_gnt, b_p1_gnt}); end
        checks++; if ({a_p0_rvalid, a_p1_rvalid, b_p0_rvalid, b_p1_rvalid} !== 4'b0000) begin
            failures++; $display("FAIL reset_rvalid: got %b want 0000", {a_p0_rvalid, a_p1_rvalid, b_p0_rvalid, b_p1_rvalid}); end
        checks++; if ((a_p0_rdata | a_p1_rdata | b_p0_rdata | b_p1_rdata) !== 64'h0) begin
            failures++; $display("FAIL reset_rdata: got %h %h %h %h want 0", a_p0_rdata, a_p1_rdata, b_p0_rdata, b_p1_rdata); end
        step();
        idle();
        rst_n = 1'b1;
        m_prio = 1'b0;
    endtask

    task automatic test_single();
        logic [63:0] e;
        p0_drive(1'b1, 8'hFF, 10'h10, 64'h0123_4567_89AB_CDEF);
        #1;
        checks++; if (a_p0_gnt !== 1'b1) begin failures++; $display("FAIL single_wr_gnt: got %b want 1", a_p0_gnt); end
        step();
        p0_drive(1'b0, 8'h00, 10'h10, 64'h0);
        #1;
        checks++; if (a_p0_gnt !== 1'b1) begin failures++; $display("FAIL single_rd_gnt: got %b want 1", a_p0_gnt); end
        q0.push_back(64'h0123_4567_89AB_CDEF);
        step();
        idle();
        checks++; if (a_p0_rvalid !== 1'b1) begin failures++; $display("FAIL single_rvalid: got %b want 1", a_p0_rvalid); end
        e = q0.pop_front();
        checks++; if (a_p0_rdata !== e) begin failures++; $display("FAIL single_rdata: got %h want %h", a_p0_rdata, e); end
        step();
        checks++; if (a_p0_rvalid !== 1'b0) begin failures++; $display("FAIL single_pulse: got %b want 0", a_p0_rvalid); end
        checks++; if (a_p0_rdata !== e) begin failures++; $display("FAIL single_hold: got %h want %h", a_p0_rdata, e); end
    endtask

    task automatic test_byte_merge();
        logic [63:0] e;
        p0_drive(1'b1, 8'hFF, 10'h5, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        p0_drive(1'b1, 8'h0F, 10'h5, 64'h0);
        step();
        p0_drive(1'b1, 8'h00, 10'h5, 64'h1234_5678_9ABC_DEF0);
        #1;
        checks++; if (a_p0_gnt !== 1'b1) begin failures++; $display("FAIL merge_zero_be_gnt: got %b want 1", a_p0_gnt); end
        step();
        p0_drive(1'b0, 8'h00, 10'h5, 64'h0);
        q0.push_back(64'hFFFF_FFFF_0000_0000);
        step();
        idle();
        checks++; if (a_p0_rvalid !== 1'b1) begin failures++; $display("FAIL merge_rvalid: got %b want 1", a_p0_rvalid); end
        e = q0.pop_front();
        checks++; if (a_p0_rdata !== e) begin failures++; $display("FAIL merge_rdata: got %h want %h", a_p0_rdata, e); end
    endtask

    task automatic test_parallel();
        logic [63:0] e;
        p0_drive(1'b1, 8'hFF, 10'h4, 64'hA5A5_5A5A_0F0F_F0F0);
        step();
        p0_drive(1'b0, 8'h00, 10'h4, 64'h0);
        p1_drive(1'b1, 8'hFF, 10'h5, 64'hDEAD_BEEF_CAFE_F00D);
        #1;
        checks++; if ({a_p0_gnt, a_p1_gnt} !== 2'b11) begin
            failures++; $display("FAIL parallel_gnt: got %b want 11", {a_p0_gnt, a_p1_gnt}); end
        q0.push_back(64'hA5A5_5A5A_0F0F_F0F0);
        step();
        checks++; if (a_p0_rvalid !== 1'b1) begin failures++; $display("FAIL parallel_p0_rvalid: got %b want 1", a_p0_rvalid); end
        e = q0.pop_front();
        checks++; if (a_p0_rdata !== e) begin failures++; $display("FAIL parallel_p0_rdata: got %h want %h", a_p0_rdata, e); end
        idle();
        p1_drive(1'b0, 8'h00, 10'h5, 64'h0);
        q1.push_back(64'hDEAD_BEEF_CAFE_F00D);
        step();
        idle();
        checks++; if (a_p1_rvalid !== 1'b1) begin failures++; $display("FAIL parallel_p1_rvalid: got %b want 1", a_p1_rvalid); end
        e = q1.pop_front();
        checks++; if (a_p1_rdata !== e) begin failures++; $display("FAIL parallel_p1_rdata: got %h want %h", a_p1_rdata, e); end
    endtask

    task automatic test_conflict();
        logic [63:0] e;
        logic        prev_w;
        p0_drive(1'b1, 8'hFF, 10'h2, 64'h2222_2222_2222_2222);
        step();
        p0_drive(1'b1, 8'hFF, 10'h6, 64'h6666_6666_6666_6666);
        step();
        idle();
        prev_w = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                checks++; if ({a_p0_rvalid, a_p1_rvalid} !== {!prev_w, prev_w}) begin
                    failures++; $display("FAIL conflict_rvalid[%0d]: got %b want %b", k, {a_p0_rvalid, a_p1_rvalid}, {!prev_w, prev_w}); end
                if (!prev_w) begin
                    e = q0.pop_front();
                    checks++; if (a_p0_rdata !== e) begin failures++; $display("FAIL conflict_p0_rdata[%0d]: got %h want %h", k, a_p0_rdata, e); end
                end else begin
                    e = q1.pop_front();
                    checks++; if (a_p1_rdata !== e) begin failures++; $display("FAIL conflict_p1_rdata[%0d]: got %h want %h", k, a_p1_rdata, e); end
                end
            end
            if (k < 3) begin
                p0_drive(1'b0, 8'h00, 10'h2, 64'h0);
                p1_drive(1'b0, 8'h00, 10'h6, 64'h0);
                #1;
                checks++; if ({a_p0_gnt, a_p1_gnt} !== {!m_prio, m_prio}) begin
                    failures++; $display("FAIL conflict_gnt[%0d]: got %b want %b", k, {a_p0_gnt, a_p1_gnt}, {!m_prio, m_prio}); end
                if (!m_prio) q0.push_back(64'h2222_2222_2222_2222);
                else         q1.push_back(64'h6666_6666_6666_6666);
                prev_w = m_prio;
                m_prio = ~m_prio;
            end else begin
                idle();
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] e;
        for (int k = 0; k < 8; k++) begin
            p0_drive(1'b1, 8'hFF, 10'(k), pat(k));
            step();
        end
        idle();
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                p0_drive(1'b0, 8'h00, 10'(k), 64'h0);
                #1;
                checks++; if (b_p0_gnt !== 1'b1) begin failures++; $display("FAIL b2b_gnt[%0d]: got %b want 1", k, b_p0_gnt); end
                q2.push_back(pat(k));
            end else begin
                idle();
            end
            step();
            checks++; if (b_p0_rvalid !== (k >= 1 && k <= 8)) begin
                failures++; $display("FAIL b2b_rvalid[%0d]: got %b want %b", k, b_p0_rvalid, (k >= 1 && k <= 8)); end
            if (k >= 1 && k <= 8) begin
                e = q2.pop_front();
                checks++; if (b_p0_rdata !== e) begin failures++; $display("FAIL b2b_rdata[%0d]: got %h want %h", k, b_p0_rdata, e); end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        logic [63:0] e;
        p0_drive(1'b0, 8'h00, 10'h10, 64'h0);
        #1;
        checks++; if (b_p0_gnt !== 1'b1) begin failures++; $display("FAIL rstmid_gnt: got %b want 1", b_p0_gnt); end
        step();
        idle();
        rst_n = 1'b0;
        m_prio = 1'b0;
        p0_drive(1'b0, 8'h00, 10'h2, 64'h0);
        p1_drive(1'b0, 8'h00, 10'h6, 64'h0);
        #1;
        checks++; if ({a_p0_gnt, a_p1_gnt, b_p0_gnt, b_p1_gnt} !== 4'b0000) begin
            failures++; $display("FAIL rstmid_gnt_forced: got %b want 0000", {a_p0_gnt, a_p1_gnt, b_p0_gnt, b_p1_gnt}); end
        checks++; if ({a_p0_rvalid, b_p0_rvalid} !== 2'b00) begin
            failures++; $display("FAIL rstmid_rvalid: got %b want 00", {a_p0_rvalid, b_p0_rvalid}); end
        checks++; if ((a_p0_rdata | b_p0_rdata) !== 64'h0) begin
            failures++; $display("FAIL rstmid_rdata: got %h %h want 0", a_p0_rdata, b_p0_rdata); end
        step();
        step();
        rst_n = 1'b1;
        #1;
        checks++; if ({a_p0_gnt, a_p1_gnt, b_p0_gnt, b_p1_gnt} !== {!m_prio, m_prio, !m_prio, m_prio}) begin
            failures++; $display("FAIL rstmid_prio: got %b want %b", {a_p0_gnt, a_p1_gnt, b_p0_gnt, b_p1_gnt}, {!m_prio, m_prio, !m_prio, m_prio}); end
        q0.push_back(pat(2));
        q2.push_back(pat(2));
        m_prio = ~m_prio;
        step();
        idle();
        checks++; if ({a_p0_rvalid, b_p0_rvalid} !== 2'b10) begin
            failures++; $display("FAIL rstmid_after1: got %b want 10", {a_p0_rvalid, b_p0_rvalid}); end
        e = q0.pop_front();
        checks++; if (a_p0_rdata !== e) begin failures++; $display("FAIL rstmid_a_rdata: got %h want %h", a_p0_rdata, e); end
        step();
        checks++; if ({a_p0_rvalid, b_p0_rvalid} !== 2'b01) begin
            failures++; $display("FAIL rstmid_after2: got %b want 01", {a_p0_rvalid, b_p0_rvalid}); end
        e = q2.pop_front();
        checks++; if (b_p0_rdata !== e) begin failures++; $display("FAIL rstmid_b_rdata: got %h want %h", b_p0_rdata, e); end
        step();
        checks++; if ({a_p0_rvalid, a_p1_rvalid, b_p0_rvalid, b_p1_rvalid} !== 4'b0000) begin
            failures++; $display("FAIL rstmid_quiet: got %b want 0000", {a_p0_rvalid, a_p1_rvalid, b_p0_rvalid, b_p1_rvalid}); end
    endtask

    initial begin
        rst_n = 1'b0;
        m_prio = 1'b0;
        idle();
        @(negedge clk);
        test_reset();
        test_single();
        test_byte_merge();
        test_parallel();
        test_conflict();
        test_back_to_back();
        test_reset_mid_read();
        checks++; if (q0.size() + q1.size() + q2.size() != 0) begin
            failures++; $display("FAIL scoreboard_drain: got %0d pending want 0", q0.size() + q1.size() + q2.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/banked_ram.md
# banked_ram

Parametrised two-port, multi-bank synchronous RAM with byte-write enables, per-port request/grant handshake and a configurable read pipeline. Replaces the single-port `cs`/`web` RAM in the FPGA memory subsystem: the core data port uses port 0 and the accelerator DMA uses port 1. Banks are address-interleaved so both ports proceed in parallel unless they target the same bank, in which case a round-robin arbiter serialises them.

## Interface
- `DATA_WIDTH`, 64: word width in bits; multiple of 8, 8..256.
- `ADDR_WIDTH`, 20: word address width per port.
- `NUM_BANKS`, 4: power of two, 1..16; `BANK_BITS = log2(NUM_BANKS)` (0 when 1).
- `READ_LATENCY`, 1: cycles from granted read to `rvalid`; legal values 1 or 2.

Ports (`p` = 0,1; each port has an identical set):
- `clk`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `p<p>_req`  in  1  access request.
- `p<p>_we`  in  1  1 = write, 0 = read.
- `p<p>_be`  in  DATA_WIDTH/8  byte enables for writes; ignored on reads.
- `p<p>_addr`  in  ADDR_WIDTH  word address.
- `p<p>_wdata`  in  DATA_WIDTH  write data.
- `p<p>_gnt`  out  1  combinational grant; access is taken on this edge when `req && gnt`.
- `p<p>_rvalid`  out  1  one-cycle pulse, read data valid.
- `p<p>_rdata`  out  DATA_WIDTH  read data; holds last value between pulses.

## Operation
- Bank = `addr[BANK_BITS-1:0]`; row = `addr[ADDR_WIDTH-1:BANK_BITS]`; bank depth 2^(ADDR_WIDTH-BANK_BITS).
- Each bank performs at most one access per cycle.
- Grant: a requesting port is granted if the other port does not request the same bank, or if it holds priority.
- Conflict (both `req`, same bank): the priority port is granted. After the conflict, priority moves to the loser. Priority changes only on conflict cycles. Reset gives priority to port 0.
- A port with `req && !gnt` must hold `we/be/addr/wdata` stable until granted. A requester is never starved for more than 1 cycle.
- Write: for each byte i with `be[i]=1`, `mem[bank][row][8i+7:8i] <= wdata[8i+7:8i]`. Other bytes are unchanged. All-zero `be` is granted and has no effect.
- Read: data is captured from the bank at the grant edge. It is routed back to the requesting port, so the bank-to-port return path is tracked per pipeline stage.
- Memory contents are not reset; reading an unwritten location returns X in simulation.
- There is no tri-state output; `rdata` is always driven.

## Timing
- `gnt` has zero latency (combinational from `req`, `addr` and the priority register). Ports may issue back-to-back accesses every cycle.
- `READ_LATENCY=1`: read granted at edge N gives `rvalid=1` and valid `rdata` in the cycle after edge N.
- `READ_LATENCY=2`: adds an output register, so `rvalid` and `rdata` appear one cycle later. Throughput stays one read per port per cycle.
- Read after write: a write granted at edge N is visible to any read granted at edge N+1 or later, on either port.
- Reset asserted: `rvalid=0`, `rdata=0`, priority = port 0, all in-flight reads are discarded. `gnt` is forced to 0 while `rst_n=0`.
- Reset mid-operation: no `rvalid` is produced after deassertion for reads granted before reset.
- After `rst_n` rises, the first edge can already grant.

## Test plan
- Single port, LAT=1: write 0x0123456789ABCDEF to addr 0x10 with `be=0xFF`, then read 0x10 → `p0_rvalid` 1 cycle after grant with data 0x0123456789ABCDEF.
- Byte merge: write 0xFF..FF to addr 5, then write 0x0 with `be=0x0F`, then read → 0xFFFFFFFF00000000.
- Parallel banks: p0 reads addr 0x4 (bank 0) while p1 writes addr 0x5 (bank 1) on the same edge → both `gnt=1`, no stall.
- Conflict: p0 and p1 both request bank 2 (addrs 0x2, 0x6) for 3 consecutive cycles. Required grant order: p0, p1, p0. Data returns to the correct ports.
- `READ_LATENCY=2`: back-to-back reads of addrs 0..7 → `rvalid` high for 8 consecutive cycles starting 2 cycles after the first grant, with data in address order.
- Reset mid-read: read granted, then `rst_n` pulled low before `rvalid` → `rvalid` and `rdata` are 0, no late pulse after release, and priority is back to p0.
